// File: rtl/logic_op_sequencer.sv
// Logic-op sequencer: ORA/AND/EOR/BIT on the accumulator. The operand comes
// from an immediate or from a memory read with a timeout.
module logic_op_sequencer #(
    parameter int DBW     = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           imm,
    input  logic [DBW-1:0] imm_data,
    input  logic [AW-1:0]  addr,
    input  logic [DBW-1:0] acc_i,
    output logic           mem_req,
    output logic [AW-1:0]  mem_addr,
    input  logic           mem_ack,
    input  logic [DBW-1:0] mem_dat_i,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [DBW-1:0] res_o,
    output logic           acc_we,
    output logic           nz_we,
    output logic           v_we,
    output logic           n_o,
    output logic           z_o,
    output logic           v_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_ORA = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_EOR = 2'd2;
    localparam logic [1:0] OP_BIT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [DBW-1:0] a_q, a_d;
    logic [DBW-1:0] b_q, b_d;

    logic           mem_req_q, mem_req_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [DBW-1:0] res_q, res_d;
    logic           acc_we_q, acc_we_d;
    logic           nz_we_q, nz_we_d;
    logic           v_we_q, v_we_d;
    logic           n_q, n_d;
    logic           z_q, z_d;
    logic           v_q, v_d;

    logic [DBW-1:0] alu_r;
    logic           is_bit;

    // BIT shares the AND datapath; only its flag sources and enables differ
    always_comb begin
        alu_r = '0;
        unique case (op_q)
            OP_ORA:  alu_r = a_q | b_q;
            OP_AND:  alu_r = a_q & b_q;
            OP_EOR:  alu_r = a_q ^ b_q;
            default: alu_r = a_q & b_q;
        endcase
    end

    assign is_bit = (op_q == OP_BIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        res_d      = res_q;
        acc_we_d   = 1'b0;
        nz_we_d    = 1'b0;
        v_we_d     = 1'b0;
        n_d        = n_q;
        z_d        = z_q;
        v_d        = v_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = acc_i;
                    b_d  = imm_data;
                    if (imm) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d    = S_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr;
                        cnt_d      = CNT_INIT;
                    end
                end
            end
            S_FETCH: begin
                // an ack in the last allowed cycle still wins over the timeout
                if (mem_ack) begin
                    b_d     = mem_dat_i;
                    state_d = S_EXEC;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    mem_req_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                res_d   = alu_r;
                z_d     = (alu_r == '0);
                nz_we_d = 1'b1;
                if (is_bit) begin
                    n_d    = b_q[DBW-1];
                    v_d    = b_q[DBW-2];
                    v_we_d = 1'b1;
                end else begin
                    n_d      = alu_r[DBW-1];
                    acc_we_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_q      <= '0;
            acc_we_q   <= 1'b0;
            nz_we_q    <= 1'b0;
            v_we_q     <= 1'b0;
            n_q        <= 1'b0;
            z_q        <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            res_q      <= res_d;
            acc_we_q   <= acc_we_d;
            nz_we_q    <= nz_we_d;
            v_we_q     <= v_we_d;
            n_q        <= n_d;
            z_q        <= z_d;
            v_q        <= v_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign res_o    = res_q;
    assign acc_we   = acc_we_q;
    assign nz_we    = nz_we_q;
    assign v_we     = v_we_q;
    assign n_o      = n_q;
    assign z_o      = z_q;
    assign v_o      = v_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: directed vector table, reset corner cases,
// then random operations checked against a behavioural model.
module tb_logic_op_sequencer;

    localparam int DBW = 16;
    localparam int AW  = 16;
    localparam int TO  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic           imm;
    logic [DBW-1:0] imm_data;
    logic [AW-1:0]  addr;
    logic [DBW-1:0] acc_i;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_ack;
    logic [DBW-1:0] mem_dat_i;
    logic           busy, done, err;
    logic [DBW-1:0] res_o;
    logic           acc_we, nz_we, v_we, n_o, z_o, v_o;

    logic_op_sequencer #(.DBW(DBW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .imm(imm),
        .imm_data(imm_data), .addr(addr), .acc_i(acc_i),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_dat_i(mem_dat_i), .busy(busy), .done(done), .err(err),
        .res_o(res_o), .acc_we(acc_we), .nz_we(nz_we), .v_we(v_we),
        .n_o(n_o), .z_o(z_o), .v_o(v_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        imm;
        logic [15:0] a;
        logic [15:0] b;
        int          ackk;
        logic        poke;
        logic [15:0] res;
        logic        n, z, v, aw, nw, vw, err;
        int          dcyc;
        int          reqc;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int          got_dcyc, got_reqc, got_ndone, addr_bad;
    logic        got_busy_after;
    logic [15:0] got_res;
    logic        got_n, got_z, got_v, got_aw, got_nw, got_vw, got_err;

    // model's view of the held result/flag registers
    logic [15:0] m_res;
    logic        m_n, m_z, m_v;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_res = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic im,
                          input logic [15:0] a, input logic [15:0] b,
                          input int ackk, input logic poke,
                          input logic [15:0] ad);
        int fidx;
        @(negedge clk);
        op = o; imm = im; acc_i = a; addr = ad;
        imm_data = im ? b : 16'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        imm_data = 16'($urandom); acc_i = 16'($urandom);
        addr = 16'($urandom);
        got_dcyc = -1; got_reqc = 0; got_ndone = 0; addr_bad = 0;
        got_busy_after = 1'bx; got_res = 'x; got_err = 1'bx;
        fidx = 0;
        for (int c = 1; c <= 20; c++) begin
            start = (poke && c == 1);
            if (poke && c == 1) begin
                op = 2'd0; imm = 1'b1;
            end
            if (mem_req) begin
                got_reqc++;
                fidx++;
                if (mem_addr !== ad) addr_bad = 1;
                mem_ack = (fidx == ackk);
                mem_dat_i = (fidx == ackk) ? b : 16'($urandom);
            end else begin
                mem_ack = 1'($urandom);
                mem_dat_i = 16'($urandom);
            end
            if (done) begin
                if (got_ndone == 0) begin
                    got_dcyc = c; got_res = res_o;
                    got_n = n_o; got_z = z_o; got_v = v_o;
                    got_aw = acc_we; got_nw = nz_we; got_vw = v_we;
                    got_err = err;
                end
                got_ndone++;
            end
            if (got_ndone > 0 && c == got_dcyc + 1) got_busy_after = busy;
            if (got_ndone > 0 && c >= got_dcyc + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic compare(input vec_t v, input string tag);
        chk({tag, "/done_cyc"}, 64'(got_dcyc), 64'(v.dcyc));
        chk({tag, "/ndone"}, 64'(got_ndone), 64'd1);
        chk({tag, "/req_cyc"}, 64'(got_reqc), 64'(v.reqc));
        chk({tag, "/addr_bad"}, 64'(addr_bad), 64'd0);
        chk({tag, "/res"}, 64'(got_res), 64'(v.res));
        chk({tag, "/nzv"}, {61'd0, got_n, got_z, got_v},
            {61'd0, v.n, v.z, v.v});
        chk({tag, "/we"}, {61'd0, got_aw, got_nw, got_vw},
            {61'd0, v.aw, v.nw, v.vw});
        chk({tag, "/err"}, 64'(got_err), 64'(v.err));
        chk({tag, "/busy_after"}, 64'(got_busy_after), 64'd0);
    endtask

    // Spec-level expectation: operand rules, flag rules, latency formulas
    function automatic vec_t model(input logic [1:0] o, input logic im,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input int ackk);
        vec_t v;
        logic [15:0] r;
        v.op = o; v.imm = im; v.a = a; v.b = b; v.ackk = ackk;
        v.poke = 1'b0;
        if (!im && ackk == 0) begin
            v.res = m_res; v.n = m_n; v.z = m_z; v.v = m_v;
            v.aw = 1'b0; v.nw = 1'b0; v.vw = 1'b0; v.err = 1'b1;
            v.dcyc = TO + 1; v.reqc = TO;
            return v;
        end
        case (o)
            2'd0: r = a | b;
            2'd2: r = a ^ b;
            default: r = a & b;
        endcase
        v.res = r; v.z = (r == 0); v.nw = 1'b1; v.err = 1'b0;
        if (o == 2'd3) begin
            v.n = b[15]; v.v = b[14]; v.aw = 1'b0; v.vw = 1'b1;
        end else begin
            v.n = r[15]; v.v = m_v; v.aw = 1'b1; v.vw = 1'b0;
        end
        v.dcyc = im ? 2 : ackk + 2;
        v.reqc = im ? 0 : ackk;
        m_res = v.res; m_n = v.n; m_z = v.z; m_v = v.v;
        return v;
    endfunction

    vec_t tbl[6];
    vec_t rv;
    int   ndone_rst;
    logic [15:0] ra, rb;

    initial begin
        tbl[0] = '{2'd0, 1'b1, 16'h00F0, 16'h0F00, 0, 1'b0, 16'h0FF0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
        tbl[1] = '{2'd1, 1'b0, 16'h8001, 16'h8000, 3, 1'b0, 16'h8000,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5, 3};
        tbl[2] = '{2'd3, 1'b0, 16'h0001, 16'hC000, 1, 1'b0, 16'h0000,
                   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1};
        tbl[3] = '{2'd2, 1'b1, 16'h5A5A, 16'h5A5A, 0, 1'b1, 16'h0000,
                   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
        tbl[4] = '{2'd1, 1'b0, 16'hFFFF, 16'h1234, 0, 1'b0, 16'h0000,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5, 4};
        tbl[5] = '{2'd0, 1'b0, 16'h1234, 16'h0001, 4, 1'b0, 16'h1235,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6, 4};

        rst = 1'b1; start = 1'b0; op = '0; imm = 1'b0; imm_data = '0;
        addr = '0; acc_i = '0; mem_ack = 1'b0; mem_dat_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/outputs",
            {mem_req, mem_addr, busy, done, err, res_o, acc_we, nz_we,
             v_we, n_o, z_o, v_o}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b,
                   tbl[i].ackk, tbl[i].poke, 16'hA000 + 16'(i));
            compare(tbl[i], $sformatf("vec%0d", i));
        end

        // reset wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; imm = 1'b1; op = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_prio/busy", 64'(busy), 64'd0);
        chk("rst_prio/res", 64'(res_o), 64'd0);
        rst = 1'b0;

        // reset in the middle of a memory fetch
        @(negedge clk);
        op = 2'd1; imm = 1'b0; addr = 16'h0BEE; acc_i = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mem_ack = 1'b0;
        chk("rst_fetch/req_before", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_fetch/req_after", 64'(mem_req), 64'd0);
        chk("rst_fetch/busy_after", 64'(busy), 64'd0);
        ndone_rst = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ack = 1'($urandom);
            if (done || busy) ndone_rst++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        chk("rst_fetch/no_done", 64'(ndone_rst), 64'd0);
        m_res = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
        run_op(2'd0, 1'b1, 16'h1200, 16'h0034, 0, 1'b0, 16'h0);
        rv = model(2'd0, 1'b1, 16'h1200, 16'h0034, 0);
        compare(rv, "rst_fetch/next");

        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            logic       ri;
            int         rk;
            ro = 2'($urandom);
            ri = 1'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rk = ri ? 0 : $urandom_range(0, TO);
            run_op(ro, ri, ra, rb, rk, 1'b0, 16'($urandom));
            rv = model(ro, ri, ra, rb, rk);
            compare(rv, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
LOGIC_OP_SEQUENCER -- requirements
Module: logic_op_sequencer

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- DBW, 16, data width.
- AW, 16, address width.
- TIMEOUT, 16, maximum FETCH cycles; minimum 1.

REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, request a logic operation; sampled only in IDLE.
- op, in, 2, operation: 0=ORA, 1=AND, 2=EOR, 3=BIT.
- imm, in, 1, 1 = operand from imm_data, 0 = operand from memory.
- imm_data, in, DBW, immediate operand.
- addr, in, AW, memory operand address.
- acc_i, in, DBW, current accumulator value.
- mem_req, out, 1, memory read request.
- mem_addr, out, AW, read address.
- mem_ack, in, 1, read data valid.
- mem_dat_i, in, DBW, read data.
- busy, out, 1, high when state is not IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, timeout abort flag; valid with done.
- res_o, out, DBW, logic result.
- acc_we, out, 1, write res_o to the accumulator.
- nz_we, out, 1, update the N and Z flags.
- v_we, out, 1, update the V flag.
- n_o, out, 1, N flag value.
- z_o, out, 1, Z flag value.
- v_o, out, 1, V flag value.

Function
REQ-003 SHALL implement the states IDLE, FETCH, EXEC and DONE.
REQ-004 In IDLE with start=1 at cycle T, the block SHALL latch op, imm, imm_data, addr and acc_i, then go to EXEC (imm=1) or FETCH (imm=0) at T+1.
REQ-005 start SHALL be ignored in every state other than IDLE; latched values SHALL NOT change while busy.
REQ-006 On entering FETCH, the timeout counter SHALL load TIMEOUT-1.
REQ-007 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal the latched addr; both are registered outputs.
REQ-008 In FETCH with mem_ack=1, the block SHALL capture mem_dat_i and go to EXEC.
REQ-009 In FETCH with mem_ack=0 and counter=0, the block SHALL go to DONE with err=1.
REQ-010 In FETCH with mem_ack=0 and counter>0, the counter SHALL decrement.
REQ-011 mem_ack in the final allowed FETCH cycle (counter=0) SHALL win over timeout.
REQ-012 mem_ack outside FETCH SHALL be ignored.
REQ-013 mem_req SHALL be 0 in every state other than FETCH.
REQ-014 EXEC SHALL last exactly one cycle, compute the result into output registers, and go to DONE.
REQ-015 Result rules (B = operand): ORA res=A|B; AND res=A&B; EOR res=A^B; BIT res=A&B.
REQ-016 For ORA, AND and EOR: n_o=res[DBW-1], z_o=(res==0), acc_we=1, nz_we=1, v_we=0.
REQ-017 For BIT: z_o=(res==0), n_o=B[DBW-1], v_o=B[DBW-2], acc_we=0, nz_we=1, v_we=1.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE; acc_we, nz_we and v_we SHALL be high only in the DONE cycle.
REQ-019 On a timeout DONE: err=1, and acc_we, nz_we and v_we SHALL be 0; res_o, n_o, z_o and v_o SHALL hold their previous values.
REQ-020 Latency SHALL be: immediate, done at T+2; memory with ack sampled at cycle F, done at F+2; timeout, done at T+TIMEOUT+1.
REQ-021 A new start SHALL be accepted in the cycle after DONE, since the block is in IDLE then.
REQ-022 res_o, n_o, z_o and v_o SHALL hold their values until the next EXEC.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, clear the counter, and clear every output register to 0: mem_req, mem_addr, busy, done, err, res_o, acc_we, nz_we, v_we, n_o, z_o, v_o.
REQ-024 Reset SHALL take priority over all other inputs, including start and mem_ack in the same cycle.
REQ-025 Reset asserted mid-FETCH SHALL drop mem_req at that edge, and no done SHALL follow.

Verification (DBW=16, TIMEOUT=4)
REQ-026 Bench SHALL cover ORA immediate: acc_i=0x00F0, imm_data=0x0F00, start at T -> done at T+2, res_o=0x0FF0, n=0, z=0, acc_we=1, nz_we=1, v_we=0.
REQ-027 Bench SHALL cover AND memory with mem_ack 3 cycles after mem_req rises: acc_i=0x8001, mem_dat_i=0x8000 -> mem_req high 3 cycles, done 2 cycles after ack, res_o=0x8000, n=1, z=0.
REQ-028 Bench SHALL cover BIT memory: acc_i=0x0001, mem_dat_i=0xC000 -> res_o=0x0000, z=1, n=1, v=1, acc_we=0, nz_we=1, v_we=1.
REQ-029 Bench SHALL cover EOR immediate with equal operands 0x5A5A -> res_o=0, z=1, n=0; a start pulsed while busy -> ignored, exactly one done.
REQ-030 Bench SHALL cover timeout: memory op with no ack -> mem_req high T+1..T+4, done=1 and err=1 at T+5, all write-enables 0; repeat with ack at T+4 -> no err, done at T+6.
REQ-031 Bench SHALL cover reset mid-FETCH: rst at T+2 -> at that edge mem_req=0, busy=0, no done; a new immediate start afterwards completes normally.
